frv_mem_arbiter: RTL and testbench
==================================

// Module: frv_mem_arbiter
// PURPOSE
//  Shares one downstream SRAM-style memory port (req/gnt, recv/ack) between the core's
//  instruction and data ports, so both can drive a single frv_axi_adapter and one AXI master.
//  Selects a requester per cycle and tracks outstanding transactions in a source-ID FIFO.
//  Routes each in-order downstream response back to the port that issued it.
// PARAMETERS
//  OUTSTANDING  2     max accepted-but-unresponded transactions (1..8)
//  FIXED_PRIO   1'b0  0: round-robin; 1: data port always wins over instruction port
// PORTS
//  g_clk      in   1   global clock
//  g_resetn   in   1   synchronous reset, active low
//  i_req      in   1   instr port request; i_wen/i_strb/i_wdata/i_addr held stable until i_gnt
//  i_wen      in   1   instr write enable
//  i_strb     in   4   instr write strobe
//  i_wdata    in   32  instr write data
//  i_addr     in   32  instr address
//  i_gnt      out  1   instr request accepted this cycle
//  i_recv     out  1   instr response valid; i_error/i_rdata valid alongside
//  i_ack      in   1   instr response consumed
//  i_error    out  1   instr response error
//  i_rdata    out  32  instr read data
//  d_*        --   --  data port; identical set and meaning to i_*
//  m_req,m_wen,m_strb,m_wdata,m_addr  out  1,1,4,32,32  downstream request
//  m_gnt      in   1   downstream accepted
//  m_recv     in   1   downstream response valid (responses return in issue order)
//  m_ack      out  1   downstream response consumed
//  m_error    in   1   downstream response error
//  m_rdata    in   32  downstream read data
// BEHAVIOUR
//  - Transfers: request on req&gnt, response on recv&ack, on the same rising edge of g_clk.
//  - State: lock (1b), lock_src (1b), rr_last (1b), ID FIFO (OUTSTANDING x 1b, 0=I,1=D),
//    count (clog2(OUTSTANDING+1) bits).
//  - Reset (g_resetn=0 at edge): FIFO empty, count=0, lock=0, rr_last=D (I wins first tie).
//    While g_resetn=0: m_req, i_gnt, d_gnt, i_recv, d_recv, m_ack are forced 0.
//  - Select, when lock=0: only one port requesting -> that port. Both requesting -> D if
//    FIXED_PRIO, else the port != rr_last. When lock=1: lock_src.
//  - Downstream request: m_req = sel_req & (count != OUTSTANDING); m_* payload muxed from sel.
//    The payload mux is combinational, so request path latency is 0 cycles.
//  - Grants: sel_gnt = m_gnt & m_req; the unselected port's gnt = 0.
//  - Lock: set at the edge where m_req & !m_gnt, with lock_src=sel. Cleared on m_req&m_gnt.
//    This prevents switching source while a request is stalled.
//  - FIFO full (count==OUTSTANDING): m_req=0 and neither port is granted, even if a pop
//    happens in the same cycle. Lock is retained.
//  - On grant: push sel ID to FIFO, count+1, rr_last<=sel.
//  - Responses: head ID routes m_recv/m_error/m_rdata to i_* or d_*. The other port's recv=0.
//    m_ack = head port's ack. Pop and count-1 on m_recv&m_ack.
//  - Simultaneous push and pop: count unchanged; FIFO pointers both advance (wrap modulo
//    OUTSTANDING).
//  - m_recv with count==0 is a protocol violation: ignored, m_ack=0, no pop;
//    `ifdef FRV_ASSERTIONS flags it.
//  - i_rdata/d_rdata = m_rdata unconditionally; only recv is gated.
//  - Reset mid-transaction discards outstanding IDs. The downstream adapter is reset by the
//    same g_resetn.
// TESTING
//  1 Solo: i_req, addr 0x8000_0000, m_gnt=1 -> i_gnt same cycle, m_addr=0x8000_0000, count=1.
//    m_recv, rdata 0x13 -> i_recv=1, i_rdata=0x13, d_recv=0.
//  2 RR tie, FIXED_PRIO=0, m_gnt=1 -> grants alternate I,D,I,D from reset.
//    Responses return to I,D,I,D in order.
//  3 Lock: d_req (addr 0x1000), m_gnt=0 for 3 cycles, then i_req asserted -> m_addr stays
//    0x1000 until d_gnt, then I granted next.
//  4 Full, OUTSTANDING=2: two grants without response -> m_req=0, no gnt.
//    Pop + pending req in one cycle -> still no gnt that cycle; gnt the next.
//  5 Backpressure: m_recv=1 with head=D, d_ack=0 for 2 cycles -> m_ack=0, no pop.
//    m_error=1 propagates to d_error only.
//  6 Reset: g_resetn=0 with count=2 -> next cycle count=0, all gnt/recv/m_ack=0.
//    After release, the first tie goes to I.

Source files
------------

// File: rtl/frv_mem_arbiter.sv
// Two-port (instruction/data) to one-port memory arbiter with an in-order source-ID FIFO
// that steers each downstream response back to the port that issued the request.
module frv_mem_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        i_req,
    input  logic        i_wen,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_recv,
    input  logic        i_ack,
    output logic        i_error,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wen,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_recv,
    input  logic        d_ack,
    output logic        d_error,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_wen,
    output logic [3:0]  m_strb,
    output logic [31:0] m_wdata,
    output logic [31:0] m_addr,
    input  logic        m_gnt,
    input  logic        m_recv,
    output logic        m_ack,
    input  logic        m_error,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   lock_q;
    logic                   lock_src_q;
    logic                   rr_last_q;

    logic sel;
    logic sel_req;
    logic full;
    logic push;
    logic pop;
    logic head;
    logic route_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Source select: 0 = instruction port, 1 = data port.
    always_comb begin
        if (lock_q) begin
            sel = lock_src_q;
        end else if (i_req && d_req) begin
            sel = FIXED_PRIO ? 1'b1 : ~rr_last_q;
        end else begin
            sel = d_req;
        end
    end

    assign sel_req = sel ? d_req : i_req;
    assign full    = (count_q == CW'(OUTSTANDING));
    assign m_req   = g_resetn & sel_req & ~full;
    assign m_wen   = sel ? d_wen   : i_wen;
    assign m_strb  = sel ? d_strb  : i_strb;
    assign m_wdata = sel ? d_wdata : i_wdata;
    assign m_addr  = sel ? d_addr  : i_addr;

    assign push  = m_req & m_gnt;
    assign i_gnt = push & ~sel;
    assign d_gnt = push & sel;

    // A response with nothing outstanding is ignored rather than routed.
    assign route_valid = g_resetn & (count_q != '0);
    assign head        = fifo_q[rd_ptr_q];

    assign i_recv  = route_valid & ~head & m_recv;
    assign d_recv  = route_valid & head & m_recv;
    assign i_error = route_valid & ~head & m_error;
    assign d_error = route_valid & head & m_error;
    assign m_ack   = route_valid & (head ? d_ack : i_ack);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign pop     = m_recv & m_ack;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            rr_last_q  <= 1'b1;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                rr_last_q        <= sel;
                lock_q           <= 1'b0;
            end else if (m_req) begin
                // Stalled request: hold this source until downstream accepts it.
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef FRV_ASSERTIONS
    always_ff @(posedge g_clk) begin
        if (g_resetn && m_recv) begin
            assert (count_q != '0) else $error("m_recv with no outstanding transaction");
        end
    end
`endif

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_frv_mem_arbiter;

    localparam int unsigned OUTST = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_wen, i_gnt, i_recv, i_ack, i_error;
    logic [3:0]  i_strb;
    logic [31:0] i_wdata, i_addr, i_rdata;
    logic        d_req, d_wen, d_gnt, d_recv, d_ack, d_error;
    logic [3:0]  d_strb;
    logic [31:0] d_wdata, d_addr, d_rdata;
    logic        m_req, m_wen, m_gnt, m_recv, m_ack, m_error;
    logic [3:0]  m_strb;
    logic [31:0] m_wdata, m_addr, m_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    frv_mem_arbiter #(.OUTSTANDING(OUTST), .FIXED_PRIO(1'b0)) dut (
        .g_clk(clk), .g_resetn(resetn),
        .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_wdata(i_wdata), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_recv(i_recv), .i_ack(i_ack), .i_error(i_error), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_recv(d_recv), .d_ack(d_ack), .d_error(d_error), .d_rdata(d_rdata),
        .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
        .m_gnt(m_gnt), .m_recv(m_recv), .m_ack(m_ack), .m_error(m_error), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding sources in issue order, the pending stalled source and
    // the last granted source.
    bit ids[$];
    bit stalled;
    bit stalled_src;
    bit last_src;

    always @(negedge clk) begin
        if (run) begin
            bit s, want, e_req, hv, hd, e_irecv, e_drecv, e_mack;
            if (stalled)               s = stalled_src;
            else if (i_req && d_req)   s = ~last_src;
            else                       s = d_req;
            want    = s ? d_req : i_req;
            e_req   = resetn && want && (ids.size() < OUTST);
            hv      = resetn && (ids.size() > 0);
            hd      = hv ? ids[0] : 1'b0;
            e_irecv = hv && !hd && m_recv;
            e_drecv = hv && hd && m_recv;
            e_mack  = hv && (hd ? d_ack : i_ack);

            check("m_req", {31'd0, m_req}, {31'd0, e_req});
            check("i_gnt", {31'd0, i_gnt}, {31'd0, e_req && m_gnt && !s});
            check("d_gnt", {31'd0, d_gnt}, {31'd0, e_req && m_gnt && s});
            check("i_recv", {31'd0, i_recv}, {31'd0, e_irecv});
            check("d_recv", {31'd0, d_recv}, {31'd0, e_drecv});
            check("m_ack", {31'd0, m_ack}, {31'd0, e_mack});
            check("i_rdata", i_rdata, m_rdata);
            check("d_rdata", d_rdata, m_rdata);
            if (e_irecv) check("i_error", {31'd0, i_error}, {31'd0, m_error});
            if (e_drecv) check("d_error", {31'd0, d_error}, {31'd0, m_error});
            if (e_req) begin
                check("m_addr", m_addr, s ? d_addr : i_addr);
                check("m_wdata", m_wdata, s ? d_wdata : i_wdata);
                check("m_strb", {28'd0, m_strb}, {28'd0, s ? d_strb : i_strb});
                check("m_wen", {31'd0, m_wen}, {31'd0, s ? d_wen : i_wen});
            end

            // Advance the model to the state after the coming rising edge.
            if (!resetn) begin
                ids.delete();
                stalled  = 1'b0;
                last_src = 1'b1;
            end else begin
                if (m_recv && e_mack) void'(ids.pop_front());
                if (e_req && m_gnt) begin
                    ids.push_back(s);
                    last_src = s;
                    stalled  = 1'b0;
                end else if (e_req) begin
                    stalled     = 1'b1;
                    stalled_src = s;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; m_gnt = 0; m_recv = 0; m_error = 0; i_ack = 0; d_ack = 0;
    endtask

    initial begin
        resetn = 0;
        idle();
        i_wen = 0; i_strb = 4'h3; i_wdata = 32'hAAAA_0001; i_addr = 32'h0;
        d_wen = 1; d_strb = 4'hC; d_wdata = 32'h5555_0002; d_addr = 32'h0;
        m_rdata = 32'h0;
        run = 1'b1;
        tick(); tick();
        settle();
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        resetn = 1;

        // Solo instruction access and its response.
        tick();
        i_req = 1; i_addr = 32'h8000_0000; m_gnt = 1;
        settle();
        check("solo_i_gnt", {31'd0, i_gnt}, 32'd1);
        check("solo_m_addr", m_addr, 32'h8000_0000);
        tick();
        i_req = 0; m_gnt = 0; m_recv = 1; m_rdata = 32'h13; i_ack = 1;
        settle();
        check("solo_i_recv", {31'd0, i_recv}, 32'd1);
        check("solo_i_rdata", i_rdata, 32'h13);
        check("solo_d_recv", {31'd0, d_recv}, 32'd0);
        tick();
        idle();

        // Round-robin ties from reset alternate I, D, I, D.
        resetn = 0;
        tick();
        resetn = 1;
        for (int k = 0; k < 4; k++) begin
            i_req = 1; d_req = 1; m_gnt = 1;
            i_addr = 32'h100 + k; d_addr = 32'h200 + k;
            m_recv = (k > 0); i_ack = 1; d_ack = 1; m_rdata = 32'h40 + k;
            settle();
            check("rr_i_gnt", {31'd0, i_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_d_gnt", {31'd0, d_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) check("rr_i_recv", {31'd0, i_recv}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        i_req = 0; d_req = 0; m_gnt = 0; m_recv = 1;
        settle();
        check("rr_last_d_recv", {31'd0, d_recv}, 32'd1);
        tick();
        idle();

        // Stalled data request keeps the lock even when the tie would favour I.
        d_req = 1; d_addr = 32'h1000; i_addr = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) i_req = 1;
            settle();
            check("lock_m_addr", m_addr, 32'h1000);
            check("lock_no_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
            tick();
        end
        m_gnt = 1;
        settle();
        check("lock_d_gnt", {31'd0, d_gnt}, 32'd1);
        check("lock_addr_at_gnt", m_addr, 32'h1000);
        tick();
        d_req = 0;
        settle();
        check("lock_then_i_gnt", {31'd0, i_gnt}, 32'd1);
        check("lock_then_i_addr", m_addr, 32'h2000);
        tick();
        idle();
        m_recv = 1; i_ack = 1; d_ack = 1;
        tick(); tick();
        idle();

        // Full FIFO blocks grants even in the cycle of a pop.
        i_req = 1; m_gnt = 1; i_addr = 32'h300;
        tick(); tick();
        settle();
        check("full_m_req", {31'd0, m_req}, 32'd0);
        check("full_i_gnt", {31'd0, i_gnt}, 32'd0);
        tick();
        m_recv = 1; i_ack = 1;
        settle();
        check("full_pop_recv", {31'd0, i_recv}, 32'd1);
        check("full_pop_no_gnt", {31'd0, i_gnt}, 32'd0);
        tick();
        m_recv = 0;
        settle();
        check("full_gnt_after", {31'd0, i_gnt}, 32'd1);
        tick();
        i_req = 0; m_gnt = 0; m_recv = 1;
        tick(); tick();
        idle();

        // Backpressure on a data response carrying an error.
        d_req = 1; m_gnt = 1;
        tick();
        d_req = 0; m_gnt = 0; m_recv = 1; m_error = 1; d_ack = 0; i_ack = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("bp_m_ack", {31'd0, m_ack}, 32'd0);
            check("bp_d_error", {31'd0, d_error}, 32'd1);
            check("bp_i_error", {31'd0, i_error}, 32'd0);
            check("bp_i_recv", {31'd0, i_recv}, 32'd0);
            tick();
        end
        d_ack = 1;
        settle();
        check("bp_m_ack_rel", {31'd0, m_ack}, 32'd1);
        tick();
        idle();

        // Reset with two outstanding transactions.
        i_req = 1; d_req = 1; m_gnt = 1;
        tick(); tick();
        resetn = 0; m_recv = 1; i_ack = 1; d_ack = 1;
        settle();
        check("rst_gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
        check("rst_recvs", {30'd0, i_recv, d_recv}, 32'd0);
        check("rst_m_ack", {31'd0, m_ack}, 32'd0);
        tick();
        resetn = 1; m_recv = 0;
        settle();
        check("post_rst_i_gnt", {31'd0, i_gnt}, 32'd1);
        check("post_rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        tick();
        settle();
        check("post_rst_d_next", {31'd0, d_gnt}, 32'd1);
        tick();
        idle();
        tick();

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
